tlb_fence_seq: RTL and testbench

- Sequences decoded TLB-fence instructions (sfence.vma, sinval.vma, sfence.w.inval, sfence.inval.ir, hfence.vvma, hfence.gvma) into flush transactions to the ITLB and DTLB.
- Sits in the privileged unit beside the privileged-instruction decoder.
- Stalls the M stage, waits for outstanding memory traffic to drain, then holds a flush request until both TLBs acknowledge, and signals completion or timeout.

---
 rtl/tlb_fence_seq_if.sv | 44 ++++
 rtl/tlb_fence_seq.sv | 127 ++++++++++++
 tb/tb_tlb_fence_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_fence_seq_if.sv
// Fence-sequencer bundle: decoded fence inputs from the M stage and the
// flush request/response toward the ITLB/DTLB.
interface tlb_fence_seq_if #(
    parameter int XLEN    = 64,
    parameter int ASIDLEN = 16
);
    logic               sfencevmaM;
    logic               hfencevvmaM;
    logic               hfencegvmaM;
    logic               VirtModeM;
    logic               Rs1ZeroM;
    logic               Rs2ZeroM;
    logic [XLEN-1:0]    FenceVAM;
    logic [ASIDLEN-1:0] FenceASIDM;
    logic               TrapM;
    logic               LSUBusyM;
    logic               ITLBFlushAck;
    logic               DTLBFlushAck;

    logic               FenceStallM;
    logic               TLBFlushReq;
    logic [1:0]         TLBFlushKind;
    logic               TLBFlushAllVA;
    logic               TLBFlushAllID;
    logic [XLEN-1:0]    TLBFlushVA;
    logic [ASIDLEN-1:0] TLBFlushID;
    logic               FenceDoneM;
    logic               FenceTimeoutM;

    // master: the fence sequencer; slave: pipeline/TLB side
    modport master (
        input  sfencevmaM, hfencevvmaM, hfencegvmaM, VirtModeM, Rs1ZeroM, Rs2ZeroM,
               FenceVAM, FenceASIDM, TrapM, LSUBusyM, ITLBFlushAck, DTLBFlushAck,
        output FenceStallM, TLBFlushReq, TLBFlushKind, TLBFlushAllVA, TLBFlushAllID,
               TLBFlushVA, TLBFlushID, FenceDoneM, FenceTimeoutM
    );

    modport slave (
        output sfencevmaM, hfencevvmaM, hfencegvmaM, VirtModeM, Rs1ZeroM, Rs2ZeroM,
               FenceVAM, FenceASIDM, TrapM, LSUBusyM, ITLBFlushAck, DTLBFlushAck,
        input  FenceStallM, TLBFlushReq, TLBFlushKind, TLBFlushAllVA, TLBFlushAllID,
               TLBFlushVA, TLBFlushID, FenceDoneM, FenceTimeoutM
    );
endinterface

// File: rtl/tlb_fence_seq.sv
// TLB fence sequencer: stalls M, drains the LSU, then holds a flush request
// until both TLBs acknowledge, reporting completion or timeout.
//
// state | meaning
// IDLE  | no fence in flight; a legal, untrapped fence starts a sequence
// DRAIN | stalled, waiting for outstanding LSU traffic; a trap aborts
// FLUSH | flush request held until both TLB acks are seen or timeout
// DONE  | one-cycle completion pulse
// TOUT  | one-cycle timeout pulse
module tlb_fence_seq #(
    parameter int XLEN        = 64,
    parameter int ASIDLEN     = 16,
    parameter int TIMEOUT_BIT = 7
) (
    input logic             clk,
    input logic             reset,
    tlb_fence_seq_if.master fenceIf
);
    typedef enum logic [2:0] {IDLE, DRAIN, FLUSH, DONE, TOUT} state_t;

    state_t               state, stateNext;
    logic [1:0]           kindQ;
    logic                 allVAQ, allIDQ;
    logic [XLEN-1:0]      vaQ;
    logic [ASIDLEN-1:0]   idQ;
    logic                 iAckSeen, dAckSeen;
    logic [TIMEOUT_BIT:0] waitCnt;

    logic       start, iSeen, dSeen;
    logic [1:0] startKind;
    logic       stall, flushReq, done, timeout;

    assign start = (fenceIf.sfencevmaM | fenceIf.hfencevvmaM | fenceIf.hfencegvmaM) & ~fenceIf.TrapM;

    // An sfence issued from VS/VU targets the guest stage, same as hfence.vvma
    assign startKind = fenceIf.hfencegvmaM ? 2'b10 :
                       (fenceIf.hfencevvmaM | (fenceIf.sfencevmaM & fenceIf.VirtModeM)) ? 2'b01 : 2'b00;

    assign iSeen = iAckSeen | fenceIf.ITLBFlushAck;
    assign dSeen = dAckSeen | fenceIf.DTLBFlushAck;

    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        flushReq  = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext = DRAIN;
                    stall     = 1'b1;
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (fenceIf.TrapM)          stateNext = IDLE;
                else if (!fenceIf.LSUBusyM) stateNext = FLUSH;
            end
            FLUSH: begin
                stall    = 1'b1;
                flushReq = 1'b1;
                // a final ack in the timeout cycle still completes the fence
                if (iSeen && dSeen)          stateNext = DONE;
                else if (waitCnt[TIMEOUT_BIT]) stateNext = TOUT;
            end
            DONE: begin
                stall     = 1'b1;
                done      = 1'b1;
                stateNext = IDLE;
            end
            TOUT: begin
                stall     = 1'b1;
                timeout   = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kindQ  <= 2'b00;
            allVAQ <= 1'b0;
            allIDQ <= 1'b0;
            vaQ    <= '0;
            idQ    <= '0;
        end else if (state == IDLE && start) begin
            kindQ  <= startKind;
            allVAQ <= fenceIf.Rs1ZeroM;
            allIDQ <= fenceIf.Rs2ZeroM;
            vaQ    <= fenceIf.FenceVAM;
            idQ    <= fenceIf.FenceASIDM;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iAckSeen <= 1'b0;
            dAckSeen <= 1'b0;
            waitCnt  <= '0;
        end else if (state != FLUSH) begin
            iAckSeen <= 1'b0;
            dAckSeen <= 1'b0;
            waitCnt  <= '0;
        end else begin
            iAckSeen <= iSeen;
            dAckSeen <= dSeen;
            if (!waitCnt[TIMEOUT_BIT]) waitCnt <= waitCnt + 1'b1;
        end
    end

    assign fenceIf.FenceStallM   = stall;
    assign fenceIf.TLBFlushReq   = flushReq;
    assign fenceIf.TLBFlushKind  = kindQ;
    assign fenceIf.TLBFlushAllVA = allVAQ;
    assign fenceIf.TLBFlushAllID = allIDQ;
    assign fenceIf.TLBFlushVA    = vaQ;
    assign fenceIf.TLBFlushID    = idQ;
    assign fenceIf.FenceDoneM    = done;
    assign fenceIf.FenceTimeoutM = timeout;
endmodule

// File: tb/tb_tlb_fence_seq.sv
// Bench for tlb_fence_seq: vector table plus scoreboard of expected flush
// transactions, and hand-written trap/reset sequences.
module tb_tlb_fence_seq;
    localparam int TOUT_CYC = 128;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   nChecks = 0;
    int   nPass = 0;

    tlb_fence_seq_if #(.XLEN(64), .ASIDLEN(16)) ifc ();
    tlb_fence_seq #(.XLEN(64), .ASIDLEN(16), .TIMEOUT_BIT(7)) dut (
        .clk    (clk),
        .reset  (reset),
        .fenceIf(ifc.master)
    );

    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        logic        sf, vv, gv, virt, r1z, r2z;
        logic [63:0] va;
        logic [15:0] id;
        int          busy, iAt, dAt;
        logic        level;
        int          trapAt;
        logic [1:0]  expKind;
    } vec_t;

    typedef struct {
        logic [1:0]  kind;
        logic        allVA, allID;
        logic [63:0] va;
        logic [15:0] id;
        logic        tout;
        int          reqCyc;
        int          pulseCyc;
    } exp_t;

    exp_t sbQ[$];
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic vec_t mkVec(input logic sf, vv, gv, virt, r1z, r2z,
                                   input logic [63:0] va, input logic [15:0] id,
                                   input int busy, iAt, dAt, input logic level,
                                   input int trapAt, input logic [1:0] expKind);
        vec_t v;
        v.sf = sf; v.vv = vv; v.gv = gv; v.virt = virt; v.r1z = r1z; v.r2z = r2z;
        v.va = va; v.id = id; v.busy = busy; v.iAt = iAt; v.dAt = dAt;
        v.level = level; v.trapAt = trapAt; v.expKind = expKind;
        return v;
    endfunction

    task automatic clearInputs();
        ifc.sfencevmaM = 0; ifc.hfencevvmaM = 0; ifc.hfencegvmaM = 0; ifc.VirtModeM = 0;
        ifc.Rs1ZeroM = 0; ifc.Rs2ZeroM = 0; ifc.FenceVAM = '0; ifc.FenceASIDM = '0;
        ifc.TrapM = 0; ifc.LSUBusyM = 0; ifc.ITLBFlushAck = 0; ifc.DTLBFlushAck = 0;
    endtask

    function automatic logic ackAt(input int rel, input int at, input logic level);
        if (at < 0) return 1'b0;
        return level ? (rel >= at) : (rel == at);
    endfunction

    // Called at posedge+#1; returns at posedge+#1 of the cycle after the pulse.
    task automatic runVec(input vec_t v);
        int f, ackIdx, last;
        exp_t e;
        logic stallErr;
        f = ((v.busy > 1) ? v.busy : 1) + 1;
        ackIdx = (v.iAt < 0 || v.dAt < 0) ? 100000 : ((v.iAt > v.dAt) ? v.iAt : v.dAt);
        last = (ackIdx <= TOUT_CYC) ? f + ackIdx + 1 : f + TOUT_CYC + 1;
        e.kind = v.expKind; e.allVA = v.r1z; e.allID = v.r2z; e.va = v.va; e.id = v.id;
        e.tout = (ackIdx > TOUT_CYC); e.reqCyc = cyc + f; e.pulseCyc = cyc + last;
        sbQ.push_back(e);
        stallErr = 0;
        for (int c = 0; c <= last; c++) begin
            ifc.sfencevmaM  = (c == 0) & v.sf;
            ifc.hfencevvmaM = (c == 0) & v.vv;
            ifc.hfencegvmaM = (c == 0) & v.gv;
            ifc.VirtModeM   = v.virt;
            ifc.Rs1ZeroM    = (c == 0) ? v.r1z : ~v.r1z;
            ifc.Rs2ZeroM    = (c == 0) ? v.r2z : ~v.r2z;
            ifc.FenceVAM    = (c == 0) ? v.va : ~v.va;
            ifc.FenceASIDM  = (c == 0) ? v.id : ~v.id;
            ifc.LSUBusyM    = (c < v.busy);
            ifc.TrapM       = (c == v.trapAt);
            ifc.ITLBFlushAck = ackAt(c - f, v.iAt, v.level);
            ifc.DTLBFlushAck = ackAt(c - f, v.dAt, v.level);
            @(negedge clk);
            if (ifc.FenceStallM !== 1'b1) stallErr = 1;
            @(posedge clk);
            #1;
        end
        clearInputs();
        check("stallSpan", stallErr, 0);
    endtask

    task automatic idleCycle();
        @(negedge clk);
        check("idleStall", ifc.FenceStallM, 0);
        check("idleReq", ifc.TLBFlushReq, 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor
    initial begin
        logic reqSeen = 0;
        logic fieldErr = 0;
        int   reqCount = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0 && ifc.TLBFlushReq) begin
                if (!reqSeen) begin
                    check("reqRise", cyc, sbQ[0].reqCyc);
                    reqSeen = 1;
                end
                reqCount++;
                if (ifc.TLBFlushKind !== sbQ[0].kind || ifc.TLBFlushAllVA !== sbQ[0].allVA ||
                    ifc.TLBFlushAllID !== sbQ[0].allID || ifc.TLBFlushVA !== sbQ[0].va ||
                    ifc.TLBFlushID !== sbQ[0].id)
                    fieldErr = 1;
            end
            if (ifc.FenceDoneM || ifc.FenceTimeoutM) begin
                if (sbQ.size() == 0) begin
                    check("unexpectedPulse", 1, 0);
                end else begin
                    e = sbQ.pop_front();
                    check("pulseCycle", cyc, e.pulseCyc);
                    check("pulseType", {ifc.FenceDoneM, ifc.FenceTimeoutM}, e.tout ? 2'b01 : 2'b10);
                    check("reqCycles", reqCount, e.pulseCyc - e.reqCyc);
                    check("flushFields", fieldErr, 0);
                    check("pulseStall", ifc.FenceStallM, 1);
                    check("pulseReqLow", ifc.TLBFlushReq, 0);
                end
                reqSeen = 0; fieldErr = 0; reqCount = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        nChecks++;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        logic reqErr;
        clearInputs();
        // sf vv gv virt r1z r2z va id busy iAt dAt level trapAt kind
        vecs.push_back(mkVec(1,0,0,0,1,1, 64'h0, 16'h0, 0, 0, 0, 0, -1, 2'b00));
        vecs.push_back(mkVec(0,0,1,0,0,0, 64'h8000_1000, 16'h5, 4, 2, 3, 0, -1, 2'b10));
        vecs.push_back(mkVec(0,1,0,0,0,1, 64'hdead_beef_0000, 16'h1234, 0, 1, 6, 0, -1, 2'b01));
        vecs.push_back(mkVec(1,0,0,1,1,0, 64'h4000, 16'h22, 1, 3, 0, 0, -1, 2'b01));
        vecs.push_back(mkVec(1,1,1,1,0,0, 64'h77, 16'h9, 0, 0, 1, 0, -1, 2'b10));
        vecs.push_back(mkVec(1,1,0,0,1,1, 64'h123, 16'h3, 2, 0, 0, 0, -1, 2'b01));
        vecs.push_back(mkVec(1,0,0,0,0,0, 64'hffff_0000, 16'hbeef, 0, 0, -1, 0, -1, 2'b00));
        vecs.push_back(mkVec(1,0,0,0,0,1, 64'h5555, 16'h1, 0, 5, 128, 0, -1, 2'b00));
        vecs.push_back(mkVec(0,0,1,0,1,0, 64'h9000, 16'h44, 0, 2, 0, 1, -1, 2'b10));
        vecs.push_back(mkVec(1,0,0,0,1,1, 64'habc, 16'h6, 0, 4, 4, 0, 3, 2'b00));
        vecs.push_back(mkVec(0,1,0,1,0,0, {$urandom, $urandom}, 16'($urandom), 1, 0, 0, 0, -1, 2'b01));

        #1;
        check("rstStall", ifc.FenceStallM, 0);
        check("rstReq", ifc.TLBFlushReq, 0);
        check("rstKind", ifc.TLBFlushKind, 0);
        check("rstAllVA", ifc.TLBFlushAllVA, 0);
        check("rstAllID", ifc.TLBFlushAllID, 0);
        check("rstVA", ifc.TLBFlushVA, 0);
        check("rstID", ifc.TLBFlushID, 0);
        check("rstDone", ifc.FenceDoneM, 0);
        check("rstTout", ifc.FenceTimeoutM, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1;
        idleCycle();

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i]);
            if (i % 2 == 1) idleCycle();
        end
        idleCycle();

        // Start with trap in the same cycle is ignored
        ifc.sfencevmaM = 1; ifc.TrapM = 1;
        @(negedge clk);
        check("trapStartStall", ifc.FenceStallM, 0);
        @(posedge clk); #1;
        clearInputs();
        idleCycle();

        // Trap during DRAIN aborts without request or completion
        reqErr = 0;
        for (int c = 0; c < 7; c++) begin
            ifc.hfencevvmaM = (c == 0);
            ifc.LSUBusyM    = (c < 3);
            ifc.TrapM       = (c == 2);
            @(negedge clk);
            if (ifc.TLBFlushReq !== 1'b0) reqErr = 1;
            if (c == 2) check("drainTrapStall", ifc.FenceStallM, 1);
            if (c == 3) check("drainTrapIdle", ifc.FenceStallM, 0);
            @(posedge clk); #1;
        end
        clearInputs();
        check("drainTrapNoReq", reqErr, 0);

        // Reset asserted mid-FLUSH drops everything asynchronously
        ifc.sfencevmaM = 1; ifc.FenceVAM = 64'h1234_5678; ifc.FenceASIDM = 16'h7; ifc.Rs2ZeroM = 1;
        @(posedge clk); #1;
        clearInputs();
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("midFlushReq", ifc.TLBFlushReq, 1);
        check("midFlushVA", ifc.TLBFlushVA, 64'h1234_5678);
        #2 reset = 0;
        #1;
        check("asyncRstReq", ifc.TLBFlushReq, 0);
        check("asyncRstStall", ifc.FenceStallM, 0);
        check("asyncRstVA", ifc.TLBFlushVA, 0);
        check("asyncRstID", ifc.TLBFlushID, 0);
        check("asyncRstAllID", ifc.TLBFlushAllID, 0);
        @(posedge clk); #1;
        reset = 1;
        runVec(mkVec(1,0,0,1,1,1, 64'h42, 16'h2, 0, 0, 0, 0, -1, 2'b01));
        repeat (3) idleCycle();

        check("scoreboardEmpty", sbQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
